// File: rtl/regfile_pkg.sv
// Shared constants and types for the MIPS register file and its read ports.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: selects current or next-state storage and busy,
// forces the zero register, and holds its outputs while rd_en is low.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int DEPTH   = 2**ADDR_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rd_en,
  input  logic [ADDR_W-1:0]            rd_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0] mem_pre,
  input  logic [DEPTH-1:0][DATA_W-1:0] mem_post,
  input  logic [DEPTH-1:0]             busy_pre,
  input  logic [DEPTH-1:0]             busy_post,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         rd_busy
);

  logic [DATA_W-1:0] data_d, data_q;
  logic              busy_d, busy_q;
  logic              is_zero;

  assign is_zero = (ZERO_REG != 0) && (rd_addr == ADDR_W'(REG_ZERO));

  // NOTE: every variable gets its hold value first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    data_d = data_q;
    busy_d = busy_q;
    if (rd_en) begin
      if (is_zero) begin
        data_d = '0;
        busy_d = 1'b0;
      end else if (BYPASS != 0) begin
        // Next-state values already include B priority and set-over-clear.
        data_d = mem_post[rd_addr];
        busy_d = busy_post[rd_addr];
      end else begin
        data_d = mem_pre[rd_addr];
        busy_d = busy_pre[rd_addr];
      end
    end
  end

  // NOTE: flops use non-blocking assignments so every register samples the
  // values from before the edge; combinational blocks use blocking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      busy_q <= 1'b0;
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign rd_data = data_q;
  assign rd_busy = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port MIPS register file: two write ports (B wins on collision),
// NUM_RD registered read ports and a per-register busy scoreboard.
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     bsy_set,
  input  logic [ADDR_W-1:0]        bsy_addr
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem_d, mem_q;
  logic [DEPTH-1:0]             busy_d, busy_q;
  logic                         wa_wr, wb_wr, bsy_wr;

  // Accesses to the hardwired zero register are dropped at the source.
  assign wa_wr  = wa_en   && !((ZERO_REG != 0) && (wa_addr  == ADDR_W'(REG_ZERO)));
  assign wb_wr  = wb_en   && !((ZERO_REG != 0) && (wb_addr  == ADDR_W'(REG_ZERO)));
  assign bsy_wr = bsy_set && !((ZERO_REG != 0) && (bsy_addr == ADDR_W'(REG_ZERO)));

  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    // Port B is applied last so it overwrites port A on an address collision.
    if (wa_wr) begin
      mem_d[wa_addr]  = wa_data;
      busy_d[wa_addr] = 1'b0;
    end
    if (wb_wr) begin
      mem_d[wb_addr]  = wb_data;
      busy_d[wb_addr] = 1'b0;
    end
    // A newly issued producer supersedes a writeback clearing the same entry.
    if (bsy_wr) begin
      busy_d[bsy_addr] = 1'b1;
    end
  end

  // NOTE: the storage array is reset along with the scoreboard, so every
  // register reads 0 after reset rather than power-up garbage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
    ) u_rd_port (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr[k*ADDR_W +: ADDR_W]),
      .mem_pre   (mem_q),
      .mem_post  (mem_d),
      .busy_pre  (busy_q),
      .busy_post (busy_d),
      .rd_data   (rd_data[k*DATA_W +: DATA_W]),
      .rd_busy   (rd_busy[k])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two instances (bypass+zero reg, and read-first with
// a writable R0) checked against an array-based model every cycle.
module tb_reg_file_mp;
  import regfile_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic             wa_en, wb_en, bsy_set;
  logic [AW-1:0]    wa_addr, wb_addr, bsy_addr;
  logic [DW-1:0]    wa_data, wb_data;
  logic [NR*DW-1:0] d1, d0;
  logic [NR-1:0]    b1, b0;

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(d1), .rd_busy(b1),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .bsy_set(bsy_set), .bsy_addr(bsy_addr)
  );

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(d0), .rd_busy(b0),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .bsy_set(bsy_set), .bsy_addr(bsy_addr)
  );

  typedef struct {
    int        rd_en, ra0, ra1;
    int        wa_en, wa_addr;
    reg_data_t wa_data;
    int        wb_en, wb_addr;
    reg_data_t wb_data;
    int        bsy_set, bsy_addr;
    reg_data_t e1d0; int e1b0; reg_data_t e1d1; int e1b1;
    reg_data_t e0d0; int e0b0; reg_data_t e0d1; int e0b1;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  // Model state: index 0 = dut (bypass, zero reg), 1 = dut0 (read-first, no zero reg)
  reg_data_t m_reg [2][DEPTH];
  bit        m_busy[2][DEPTH];
  reg_data_t m_d   [2][NR];
  bit        m_b   [2][NR];

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < DEPTH; r++) begin
        m_reg[i][r]  = '0;
        m_busy[i][r] = 1'b0;
      end
      for (int k = 0; k < NR; k++) begin
        m_d[i][k] = '0;
        m_b[i][k] = 1'b0;
      end
    end
  endfunction

  // Applies the current inputs to the model as the coming clock edge would.
  function automatic void model_step();
    for (int i = 0; i < 2; i++) begin
      bit bp = (i == 0);
      bit zr = (i == 0);
      bit wra = wa_en   && !(zr && wa_addr  == 0);
      bit wrb = wb_en   && !(zr && wb_addr  == 0);
      bit st  = bsy_set && !(zr && bsy_addr == 0);
      if (rd_en) begin
        for (int k = 0; k < NR; k++) begin
          int a = int'(rd_addr[k*AW +: AW]);
          bit hit_a = wra && (int'(wa_addr) == a);
          bit hit_b = wrb && (int'(wb_addr) == a);
          if (zr && a == 0) begin
            m_d[i][k] = '0;
            m_b[i][k] = 1'b0;
          end else if (bp) begin
            m_d[i][k] = hit_b ? wb_data : (hit_a ? wa_data : m_reg[i][a]);
            m_b[i][k] = (st && int'(bsy_addr) == a) ? 1'b1 :
                        ((hit_a || hit_b) ? 1'b0 : m_busy[i][a]);
          end else begin
            m_d[i][k] = m_reg[i][a];
            m_b[i][k] = m_busy[i][a];
          end
        end
      end
      if (wra) begin m_reg[i][wa_addr] = wa_data; m_busy[i][wa_addr] = 1'b0; end
      if (wrb) begin m_reg[i][wb_addr] = wb_data; m_busy[i][wb_addr] = 1'b0; end
      if (st)  m_busy[i][bsy_addr] = 1'b1;
    end
  endfunction

  function automatic logic [31:0] got_d(int i, int k);
    return (i == 0) ? d1[k*DW +: DW] : d0[k*DW +: DW];
  endfunction

  function automatic logic [31:0] got_b(int i, int k);
    return (i == 0) ? 32'(b1[k]) : 32'(b0[k]);
  endfunction

  task automatic set_in(int en, int ra0, int ra1, int wae, int waa, reg_data_t wad,
                        int wbe, int wba, reg_data_t wbd, int bs, int ba);
    rd_en    = (en != 0);
    rd_addr  = {AW'(ra1), AW'(ra0)};
    wa_en    = (wae != 0);
    wa_addr  = AW'(waa);
    wa_data  = wad;
    wb_en    = (wbe != 0);
    wb_addr  = AW'(wba);
    wb_data  = wbd;
    bsy_set  = (bs != 0);
    bsy_addr = AW'(ba);
  endtask

  task automatic idle_read(int ra0, int ra1);
    set_in(1, ra0, ra1, 0, 0, '0, 0, 0, '0, 0, 0);
  endtask

  task automatic tick(string tag);
    model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < NR; k++) begin
        check($sformatf("%s_i%0d_p%0d_data", tag, i, k), got_d(i, k), m_d[i][k]);
        check($sformatf("%s_i%0d_p%0d_busy", tag, i, k), got_b(i, k), 32'(m_b[i][k]));
      end
    end
  endtask

  task automatic check_all_zero(string tag);
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < NR; k++) begin
        check($sformatf("%s_i%0d_p%0d_data", tag, i, k), got_d(i, k), 32'h0);
        check($sformatf("%s_i%0d_p%0d_busy", tag, i, k), got_b(i, k), 32'h0);
      end
    end
  endtask

  vec_t tbl[10];

  initial begin
    // en ra0 ra1 | waE waA waD | wbE wbA wbD | bs bA | dut: d0 b0 d1 b1 | dut0: d0 b0 d1 b1
    tbl[0] = '{1, 7, 7,  1, 7, 32'h11111111, 1, 7, 32'h22222222, 0, 0,
               32'h22222222, 0, 32'h22222222, 0,  32'h0, 0, 32'h0, 0};
    tbl[1] = '{1, 7, 3,  1, 3, 32'hA, 1, 4, 32'hB, 0, 0,
               32'h22222222, 0, 32'hA, 0,  32'h22222222, 0, 32'h0, 0};
    tbl[2] = '{1, 3, 4,  0, 0, 32'h0, 0, 0, 32'h0, 0, 0,
               32'hA, 0, 32'hB, 0,  32'hA, 0, 32'hB, 0};
    tbl[3] = '{1, 9, 9,  1, 9, 32'h12345678, 0, 0, 32'h0, 0, 0,
               32'h12345678, 0, 32'h12345678, 0,  32'h0, 0, 32'h0, 0};
    tbl[4] = '{1, 9, 0,  1, 0, 32'hFFFFFFFF, 0, 0, 32'h0, 1, 0,
               32'h12345678, 0, 32'h0, 0,  32'h12345678, 0, 32'h0, 0};
    tbl[5] = '{1, 0, 12, 0, 0, 32'h0, 0, 0, 32'h0, 1, 12,
               32'h0, 0, 32'h0, 1,  32'hFFFFFFFF, 1, 32'h0, 0};
    tbl[6] = '{1, 12, 12, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0,
               32'h0, 1, 32'h0, 1,  32'h0, 1, 32'h0, 1};
    tbl[7] = '{1, 12, 0, 1, 12, 32'hCCC, 0, 0, 32'h0, 0, 0,
               32'hCCC, 0, 32'h0, 0,  32'h0, 1, 32'hFFFFFFFF, 1};
    tbl[8] = '{1, 12, 12, 1, 12, 32'hDDDD, 0, 0, 32'h0, 1, 12,
               32'hDDDD, 1, 32'hDDDD, 1,  32'hCCC, 0, 32'hCCC, 0};
    tbl[9] = '{1, 12, 12, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0,
               32'hDDDD, 1, 32'hDDDD, 1,  32'hDDDD, 1, 32'hDDDD, 1};

    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, '0, 0, 0, '0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: conflicts, bypass, zero register, scoreboard
    for (int t = 0; t < 10; t++) begin
      set_in(tbl[t].rd_en, tbl[t].ra0, tbl[t].ra1, tbl[t].wa_en, tbl[t].wa_addr,
             tbl[t].wa_data, tbl[t].wb_en, tbl[t].wb_addr, tbl[t].wb_data,
             tbl[t].bsy_set, tbl[t].bsy_addr);
      tick($sformatf("tbl%0d", t));
      check($sformatf("vec%0d_byp_d0", t), got_d(0, 0), tbl[t].e1d0);
      check($sformatf("vec%0d_byp_b0", t), got_b(0, 0), 32'(tbl[t].e1b0));
      check($sformatf("vec%0d_byp_d1", t), got_d(0, 1), tbl[t].e1d1);
      check($sformatf("vec%0d_byp_b1", t), got_b(0, 1), 32'(tbl[t].e1b1));
      check($sformatf("vec%0d_rf_d0", t),  got_d(1, 0), tbl[t].e0d0);
      check($sformatf("vec%0d_rf_b0", t),  got_b(1, 0), 32'(tbl[t].e0b0));
      check($sformatf("vec%0d_rf_d1", t),  got_d(1, 1), tbl[t].e0d1);
      check($sformatf("vec%0d_rf_b1", t),  got_b(1, 1), 32'(tbl[t].e0b1));
    end

    // Stall hold: outputs frozen while R2 is written and addresses move
    idle_read(2, 12);
    tick("stall_pre");
    for (int j = 0; j < 3; j++) begin
      set_in(0, 5 + j, 6 + j, (j == 0) ? 1 : 0, 2, 32'h55, 0, 0, '0, (j == 1) ? 1 : 0, 2);
      tick($sformatf("stall%0d", j));
      check($sformatf("stall%0d_hold_d", j), got_d(0, 0), 32'h0);
      check($sformatf("stall%0d_hold_b", j), got_b(0, 1), 32'h1);
      check($sformatf("stall%0d_hold_rf_d", j), got_d(1, 1), 32'hDDDD);
    end
    idle_read(2, 2);
    tick("stall_post");
    check("stall_release_byp", got_d(0, 0), 32'h55);
    check("stall_release_rf",  got_d(1, 0), 32'h55);
    check("stall_release_busy", got_b(0, 0), 32'h1);

    // Reset in the middle of a write
    set_in(1, 5, 5, 1, 5, 32'hDEADBEEF, 0, 0, '0, 1, 5);
    tick("rst_wr");
    idle_read(5, 5);
    tick("rst_rd");
    check("pre_reset_r5",      got_d(0, 0), 32'hDEADBEEF);
    check("pre_reset_r5_busy", got_b(1, 1), 32'h1);
    set_in(1, 5, 5, 1, 5, 32'hCAFEF00D, 0, 0, '0, 0, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    check_all_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    idle_read(5, 5);
    tick("post_reset");
    check("post_reset_r5",    got_d(0, 0), 32'h0);
    check("post_reset_r5_rf", got_d(1, 1), 32'h0);

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      int ra0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
      int ra1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
      set_in(($urandom_range(0, 3) != 0) ? 1 : 0, ra0, ra1,
             int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), reg_data_t'($urandom()),
             int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), reg_data_t'($urandom()),
             ($urandom_range(0, 2) == 0) ? 1 : 0, int'($urandom_range(0, 7)));
      tick($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
